bitop_arbiter: RTL and testbench
================================

// Module: bitop_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one WIDTH-bit bitwise logic unit (AND/OR/XOR/NAND)
//  between NREQ requesters. Grants one requester at a time, latches its operands and opcode,
//  computes the result and returns it tagged with the requester ID. Sits between client
//  blocks and the shared bitwise datapath.
// PARAMETERS
//  WIDTH  4  operand/result width in bits
//  NREQ   4  number of requesters (2..8); IDW = $clog2(NREQ) is a localparam
// PORTS
//  i_clk      in   1           clock, rising edge
//  i_rst      in   1           reset, asynchronous, active-high
//  i_req      in   NREQ        request per requester; held until matching o_gnt bit seen
//  i_op1      in   NREQ*WIDTH  operand 1, requester k at [k*WIDTH +: WIDTH]
//  i_op2      in   NREQ*WIDTH  operand 2, same packing
//  i_opc      in   NREQ*2      opcode, requester k at [k*2 +: 2]: 00 AND, 01 OR, 10 XOR, 11 NAND
//  o_gnt      out  NREQ        one-hot grant, registered, high 1 cycle when operands are captured
//  o_busy     out  1           high while state != IDLE
//  o_res      out  WIDTH       result, valid when o_res_vld
//  o_res_id   out  IDW         requester index owning o_res
//  o_res_vld  out  1           1-cycle result strobe
// BEHAVIOUR
//  - One clock, i_clk. Reset i_rst is asynchronous and active-high.
//  - Reset: state IDLE; o_gnt=0, o_busy=0, o_res=0, o_res_id=0, o_res_vld=0;
//    last-grant pointer = NREQ-1, so requester 0 has highest priority first.
//  - FSM IDLE -> EXEC -> DONE -> IDLE:
//    IDLE: if |i_req, winner = first set bit scanning from (ptr+1) mod NREQ upward with wrap.
//      On the edge: latch winner op1/op2/opc/id, ptr <= winner, o_gnt[winner] <= 1, go EXEC.
//      If no request, stay IDLE with all outputs 0.
//    EXEC (o_gnt high this cycle): on the edge: o_res <= f(opc, op1, op2), o_res_id <= id,
//      o_res_vld <= 1, o_gnt <= 0, go DONE.
//    DONE (o_res_vld high this cycle): on the edge: o_res_vld <= 0, go IDLE. o_res/o_res_id hold
//      until the next result.
//  - Latency: request seen in IDLE at cycle n -> o_gnt at n+1 -> o_res_vld at n+2.
//    Throughput: one operation per 3 cycles.
//  - A requester drops i_req on the edge after it sees its o_gnt. The next arbitration
//    (IDLE) therefore never sees a stale request.
//  - Requests that change or drop while not granted are ignored. Only IDLE samples i_req.
//  - Simultaneous requests are resolved only by round-robin order. A requester that is
//    continuously asserted waits at most NREQ-1 grants.
//  - Results are exactly WIDTH bits; NAND = ~(op1 & op2) truncated to WIDTH. No carry or status.
//  - Reset asserted mid-operation aborts it immediately: no o_res_vld for the aborted
//    request, and the pointer returns to NREQ-1.
// CONFIGURATION
//  BITOP_ARB_STATS_EN defined: adds port o_op_cnt (out, 16) = count of o_res_vld strobes
//    since reset. It saturates at 16'hFFFF and resets to 0.
//  Not defined: o_op_cnt port and counter are absent; all other behaviour is identical.
// TESTING
//  1. Reset, then req=4'b0001, op1=4'hA, op2=4'hC, opc=11 -> gnt=0001 next cycle;
//     o_res=4'h7, o_res_id=0, o_res_vld 2 cycles after request.
//  2. All 4 requesters held continuously, each dropping after its own grant -> grant order 0,1,2,3;
//     grants spaced 3 cycles apart; results AND/OR/XOR/NAND correct per opcode.
//  3. req0 and req2 re-requesting forever -> grants alternate 0,2,0,2; no starvation.
//  4. Exhaustive: every op1/op2 in 0..15 x all 4 opcodes via requester 1 -> 0 mismatches against
//     the expected Verilog expression.
//  5. Assert i_rst during EXEC -> all outputs 0 asynchronously; no o_res_vld;
//     next grant goes to lowest-index requester.
//  6. With BITOP_ARB_STATS_EN: 5 ops -> o_op_cnt=5. Force the counter to 16'hFFFE, run 3 ops ->
//     o_op_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/bitop_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bitop_arbiter
//  Purpose  : Round-robin arbiter/sequencer sharing one WIDTH-bit bitwise
//             logic unit (AND/OR/XOR/NAND) between NREQ requesters. Grants
//             one requester at a time, latches its operands and opcode,
//             computes the result and returns it tagged with the requester ID.
//  Ports    : i_clk      clock, rising edge
//             i_rst      asynchronous active-high reset
//             i_req      per-requester request, held until its grant is seen
//             i_op1      operand 1, requester k at [k*WIDTH +: WIDTH]
//             i_op2      operand 2, same packing
//             i_opc      opcode, requester k at [k*2 +: 2]
//                        (00 AND, 01 OR, 10 XOR, 11 NAND)
//             o_gnt      one-hot registered grant, 1 cycle at operand capture
//             o_busy     high while an operation is in flight
//             o_res      result, valid with o_res_vld, held afterwards
//             o_res_id   index of the requester owning o_res
//             o_res_vld  1-cycle result strobe
//             o_op_cnt   (BITOP_ARB_STATS_EN only) saturating count of
//                        o_res_vld strobes since reset
//  Config   : define BITOP_ARB_STATS_EN to add the o_op_cnt port/counter.
//  Revision : 1.0  initial release
// ============================================================================
module bitop_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NREQ-1:0]           i_req,
  input  logic [NREQ*WIDTH-1:0]     i_op1,
  input  logic [NREQ*WIDTH-1:0]     i_op2,
  input  logic [NREQ*2-1:0]         i_opc,
  output logic [NREQ-1:0]           o_gnt,
  output logic                      o_busy,
  output logic [WIDTH-1:0]          o_res,
  output logic [$clog2(NREQ)-1:0]   o_res_id,
  output logic                      o_res_vld
`ifdef BITOP_ARB_STATS_EN
  ,
  output logic [15:0]               o_op_cnt
`endif
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  logic [1:0]       r_opc;

  logic             w_any;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_idx;

  function automatic logic [WIDTH-1:0] bitop(input logic [1:0]       opc,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (opc)
      2'b00:   bitop = a & b;
      2'b01:   bitop = a | b;
      2'b10:   bitop = a ^ b;
      default: bitop = ~(a & b);
    endcase
  endfunction

  // Scan starts one past the last winner and wraps, so the first set bit
  // found is the round-robin winner.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = IDW'((int'(r_ptr) + i) % NREQ);
      if (!w_any && i_req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign o_busy = (r_state != c_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= c_IDLE;
      r_ptr     <= IDW'(NREQ - 1);
      r_id      <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_opc     <= '0;
      o_gnt     <= '0;
      o_res     <= '0;
      o_res_id  <= '0;
      o_res_vld <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          o_gnt     <= '0;
          o_res_vld <= 1'b0;
          if (w_any) begin
            r_op1   <= i_op1[int'(w_win)*WIDTH +: WIDTH];
            r_op2   <= i_op2[int'(w_win)*WIDTH +: WIDTH];
            r_opc   <= i_opc[int'(w_win)*2 +: 2];
            r_id    <= w_win;
            r_ptr   <= w_win;
            o_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
            r_state <= c_EXEC;
          end
        end
        c_EXEC: begin
          o_res     <= bitop(r_opc, r_op1, r_op2);
          o_res_id  <= r_id;
          o_res_vld <= 1'b1;
          o_gnt     <= '0;
          r_state   <= c_DONE;
        end
        c_DONE: begin
          // o_res / o_res_id are deliberately left holding their value.
          o_res_vld <= 1'b0;
          r_state   <= c_IDLE;
        end
        default: begin
          o_gnt     <= '0;
          o_res_vld <= 1'b0;
          r_state   <= c_IDLE;
        end
      endcase
    end
  end

`ifdef BITOP_ARB_STATS_EN
  logic [15:0] r_cnt;

  // Counts on the same edge that raises o_res_vld.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_state == c_EXEC && r_cnt != 16'hFFFF) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_op_cnt = r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitop_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitop_arbiter
//  Purpose  : Self-checking bench for bitop_arbiter. A transaction-level
//             model predicts grants, results and strobes every cycle; a few
//             directed scenarios pin literal values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bitop_arbiter;
  localparam int W  = 4;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic [N-1:0]    i_req = '0;
  logic [N*W-1:0]  i_op1 = '0;
  logic [N*W-1:0]  i_op2 = '0;
  logic [N*2-1:0]  i_opc = '0;
  logic [N-1:0]    o_gnt;
  logic            o_busy;
  logic [W-1:0]    o_res;
  logic [IW-1:0]   o_res_id;
  logic            o_res_vld;
`ifdef BITOP_ARB_STATS_EN
  logic [15:0]     o_op_cnt;
`endif

  bitop_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
    .i_op1(i_op1), .i_op2(i_op2), .i_opc(i_opc),
    .o_gnt(o_gnt), .o_busy(o_busy), .o_res(o_res),
    .o_res_id(o_res_id), .o_res_vld(o_res_vld)
`ifdef BITOP_ARB_STATS_EN
    , .o_op_cnt(o_op_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  bit chk_en = 1'b0;
  bit cnt_chk = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
    case (opc)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // ---------------- transaction model ----------------
  // m_age: 0 = free, 1 = grant cycle, 2 = result cycle.
  int           m_ptr = N - 1;
  int           m_age = 0;
  logic [N-1:0] m_gnt = '0;
  logic [W-1:0] m_res = '0, m_pend_res = '0;
  int           m_id = 0, m_pend_id = 0;
  logic         m_vld = 1'b0;
  int           m_cnt = 0;

  always @(posedge i_clk or posedge i_rst) begin : model
    int w;
    if (i_rst) begin
      m_ptr <= N - 1; m_age <= 0; m_gnt <= '0; m_res <= '0;
      m_id <= 0; m_vld <= 1'b0; m_cnt <= 0;
    end else if (m_age == 0) begin
      m_gnt <= '0;
      m_vld <= 1'b0;
      w = -1;
      for (int s = 1; s <= N; s++)
        if (w < 0 && i_req[(m_ptr + s) % N]) w = (m_ptr + s) % N;
      if (w >= 0) begin
        m_ptr      <= w;
        m_gnt      <= N'(1) << w;
        m_pend_res <= ref_op(i_opc[w*2 +: 2], i_op1[w*W +: W], i_op2[w*W +: W]);
        m_pend_id  <= w;
        m_age      <= 1;
      end
    end else if (m_age == 1) begin
      m_gnt <= '0;
      m_res <= m_pend_res;
      m_id  <= m_pend_id;
      m_vld <= 1'b1;
      m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
      m_age <= 2;
    end else begin
      m_vld <= 1'b0;
      m_age <= 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge i_clk) begin
    #1;
    if (chk_en && !i_rst) begin
      check("gnt", 32'(o_gnt), 32'(m_gnt));
      check("busy", 32'(o_busy), 32'(m_age != 0));
      check("res_vld", 32'(o_res_vld), 32'(m_vld));
      check("res", 32'(o_res), 32'(m_res));
      check("res_id", 32'(o_res_id), 32'(m_id));
`ifdef BITOP_ARB_STATS_EN
      if (cnt_chk) check("op_cnt", 32'(o_op_cnt), 32'(m_cnt));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  int gq[$], tq[$], rq[$], iq[$];
  int waits[N];

  task automatic cyc();
    @(posedge i_clk);
    #1;
    cyc_n++;
  endtask

  task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] opc);
    i_op1[k*W +: W] = a;
    i_op2[k*W +: W] = b;
    i_opc[k*2 +: 2] = opc;
    i_req[k] = 1'b1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_req = '0;
    cyc(); cyc();
    i_rst = 1'b0;
    gq.delete(); tq.delete(); rq.delete(); iq.delete();
  endtask

  // Clients drop on the cycle their grant is visible; those in rereq raise
  // again one cycle later. rnd adds random new requests.
  task automatic run(input int n, input logic [N-1:0] rereq, input bit rnd);
    for (int c = 0; c < n; c++) begin
      cyc();
      for (int k = 0; k < N; k++) begin
        if (o_gnt[k]) begin
          gq.push_back(k);
          tq.push_back(cyc_n);
        end
      end
      if (o_res_vld) begin
        rq.push_back(int'(o_res));
        iq.push_back(int'(o_res_id));
      end
      if (m_gnt != 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_gnt[k]) begin
            if (rnd) check("fair_wait", 32'(waits[k]), 32'(waits[k] <= N - 1 ? waits[k] : N - 1));
            waits[k] = 0;
          end else if (i_req[k]) begin
            waits[k]++;
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (m_gnt[k]) i_req[k] = 1'b0;
        else if (!i_req[k] && rereq[k]) i_req[k] = 1'b1;
        else if (!i_req[k] && rnd && $urandom_range(0, 3) == 0)
          set_req(k, W'($urandom), W'($urandom), 2'($urandom));
      end
    end
  endtask

  initial begin
    // Reset state
    i_rst = 1'b1;
    cyc(); cyc();
    check("rst_gnt", 32'(o_gnt), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_res", 32'(o_res), 32'h0);
    check("rst_id", 32'(o_res_id), 32'h0);
    check("rst_vld", 32'(o_res_vld), 32'h0);
    i_rst = 1'b0;
    chk_en = 1'b1;

    // 1: single NAND request on requester 0
    set_req(0, 4'hA, 4'hC, 2'b11);
    cyc();
    check("t1_gnt", 32'(o_gnt), 32'h1);
    check("t1_vld_early", 32'(o_res_vld), 32'h0);
    i_req[0] = 1'b0;
    cyc();
    check("t1_res", 32'(o_res), 32'h7);
    check("t1_id", 32'(o_res_id), 32'h0);
    check("t1_vld", 32'(o_res_vld), 32'h1);
    cyc();
    check("t1_vld_drop", 32'(o_res_vld), 32'h0);
    check("t1_res_hold", 32'(o_res), 32'h7);

    // 2: all four requesters, opcode k on requester k
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 4'hA, 4'hC, 2'(k));
    run(14, '0, 1'b0);
    check("t2_ngrants", 32'(gq.size()), 32'd4);
    check("t2_nres", 32'(rq.size()), 32'd4);
    if (gq.size() == 4 && rq.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("t2_order", 32'(gq[k]), 32'(k));
        check("t2_res_id", 32'(iq[k]), 32'(k));
      end
      for (int k = 1; k < 4; k++) check("t2_spacing", 32'(tq[k] - tq[k-1]), 32'd3);
      check("t2_and", 32'(rq[0]), 32'h8);
      check("t2_or", 32'(rq[1]), 32'hE);
      check("t2_xor", 32'(rq[2]), 32'h6);
      check("t2_nand", 32'(rq[3]), 32'h7);
    end

    // 3: requesters 0 and 2 re-requesting forever
    do_reset();
    set_req(0, 4'h3, 4'h5, 2'b01);
    set_req(2, 4'h3, 4'h5, 2'b10);
    run(24, 4'b0101, 1'b0);
    check("t3_ngrants", 32'(gq.size()), 32'd8);
    for (int k = 0; k < gq.size(); k++) check("t3_alt", 32'(gq[k]), (k % 2 == 0) ? 32'd0 : 32'd2);
    i_req = '0;
    run(4, '0, 1'b0);

    // 4: exhaustive operands/opcodes through requester 1
    do_reset();
    for (int opc = 0; opc < 4; opc++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          set_req(1, W'(a), W'(b), 2'(opc));
          cyc();
          i_req[1] = 1'b0;
          cyc();
          check("t4_res", 32'(o_res), 32'(ref_op(2'(opc), W'(a), W'(b))));
          cyc();
        end

    // 5: reset during EXEC aborts the operation
    do_reset();
    set_req(0, 4'hF, 4'hF, 2'b00);
    set_req(3, 4'h1, 4'h2, 2'b01);
    cyc();
    check("t5_gnt0", 32'(o_gnt), 32'h1);
    i_req[0] = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    check("t5_abort_gnt", 32'(o_gnt), 32'h0);
    check("t5_abort_busy", 32'(o_busy), 32'h0);
    check("t5_abort_vld", 32'(o_res_vld), 32'h0);
    check("t5_abort_res", 32'(o_res), 32'h0);
    check("t5_abort_id", 32'(o_res_id), 32'h0);
    cyc(); cyc();
    i_rst = 1'b0;
    set_req(1, 4'h6, 4'h3, 2'b10);
    cyc();
    check("t5_gnt_low", 32'(o_gnt), 32'h2);
    check("t5_no_vld", 32'(o_res_vld), 32'h0);
    i_req[1] = 1'b0;
    run(6, '0, 1'b0);

    // Random traffic with fairness bound
    do_reset();
    for (int k = 0; k < N; k++) waits[k] = 0;
    run(1500, '0, 1'b1);

`ifdef BITOP_ARB_STATS_EN
    // 6: operation counter and saturation
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_req(2, 4'h1, 4'h1, 2'b00);
      cyc(); i_req[2] = 1'b0; cyc(); cyc();
    end
    check("t6_cnt5", 32'(o_op_cnt), 32'd5);
    cnt_chk = 1'b0;
    force dut.r_cnt = 16'hFFFE;
    #1;
    release dut.r_cnt;
    for (int k = 0; k < 3; k++) begin
      set_req(2, 4'h1, 4'h1, 2'b00);
      cyc(); i_req[2] = 1'b0; cyc(); cyc();
    end
    check("t6_sat", 32'(o_op_cnt), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
